// File: rtl/irq_arbiter.sv
// Interrupt arbiter: fixed-priority selection among level-sensitive sources,
// a single outstanding interrupt to the core, and a one-hot return pulse to the
// serviced source when the core executes mret.
module irq_arbiter #(
  parameter int unsigned N_SRC      = 16,
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_req_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic             irq_ack_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_SRC-1:0] irq_ret_o
);

  localparam int unsigned SEL_W   = 4;
  localparam int unsigned SRC_W   = N_SRC;
  localparam int unsigned CAUSE_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2,
    S_RET     = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [SEL_W-1:0]     sel;
  logic [SEL_W-1:0]     sel_nx;
  logic [SEL_W-1:0]     pick;
  logic [SRC_W-1:0]     pending;
  logic [SRC_W-1:0]     sel_oh;
  logic                 any_pending;
  logic                 sel_live;
  logic                 irq_nx;
  logic [CAUSE_W-1:0]   cause_nx;
  logic [SRC_W-1:0]     ret_nx;

  // Enabled requests and the one-hot view of the latched selection
  always_comb begin
    pending     = irq_req_i & mie_i;
    any_pending = |pending;
    sel_oh      = SRC_W'(1) << sel;
    sel_live    = |(pending & sel_oh);
  end

  // Fixed-priority encoder: lowest set bit wins, so scan from the top down
  always_comb begin
    pick = '0;
    for (int k = int'(SRC_W) - 1; k >= 0; k--) begin
      if (pending[k]) begin
        pick = SEL_W'(k);
      end
    end
  end

  // State register and registered outputs; reset overrides any handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      sel         <= '0;
      irq_o       <= 1'b0;
      irq_cause_o <= '0;
      irq_ret_o   <= '0;
    end else begin
      state       <= state_nx;
      sel         <= sel_nx;
      irq_o       <= irq_nx;
      irq_cause_o <= cause_nx;
      irq_ret_o   <= ret_nx;
    end
  end

  // Next-state logic; ack wins over a simultaneous withdraw in REQ
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (any_pending) begin
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack_i) begin
          state_nx = S_SERVICE;
        end else if (!sel_live) begin
          state_nx = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (mret_i) begin
          state_nx = S_RET;
        end
      end
      S_RET: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    sel_nx   = sel;
    cause_nx = irq_cause_o;
    irq_nx   = 1'b0;
    ret_nx   = '0;
    if ((state == S_IDLE) && (state_nx == S_REQ)) begin
      sel_nx   = pick;
      cause_nx = CAUSE_BASE + CAUSE_W'(pick);
    end
    if (state_nx == S_REQ) begin
      irq_nx = 1'b1;
    end
    if (state_nx == S_RET) begin
      ret_nx = sel_oh;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_irq_arbiter;

  localparam logic [31:0] BASE = 32'h8000_0010;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] mie;
  logic        ack;
  logic        mret;
  logic        irq;
  logic [31:0] cause;
  logic [15:0] ret;

  int checks   = 0;
  int failures = 0;

  irq_arbiter #(.N_SRC(16), .CAUSE_BASE(BASE)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_req_i   (req),
    .mie_i       (mie),
    .irq_ack_i   (ack),
    .mret_i      (mret),
    .irq_o       (irq),
    .irq_cause_o (cause),
    .irq_ret_o   (ret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for ack, 2 in service, 3 returning
  int          m_phase = 0;
  int          m_sel   = 0;
  logic        m_irq   = 1'b0;
  logic [31:0] m_cause = '0;
  logic [15:0] m_ret   = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [15:0] p;
    p = req & mie;
    if (rst) begin
      m_phase = 0;
      m_sel   = 0;
      m_cause = '0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        0: if (p != 16'h0) begin
             for (int k = 0; k < 16; k++) begin
               if (p[k]) begin
                 m_sel = k;
                 break;
               end
             end
             m_cause = BASE + 32'(m_sel);
             m_phase = 1;
           end
        1: if (ack) m_phase = 2;
           else if (!p[m_sel]) m_phase = 0;
        2: if (mret) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    m_irq = (m_phase == 1);
    m_ret = (m_phase == 3) ? (16'h1 << m_sel) : 16'h0;
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_irq", 32'(irq), 32'(m_irq));
      check("model_cause", cause, m_cause);
      check("model_ret", 32'(ret), 32'(m_ret));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic exp_irq, input logic [31:0] exp_cause,
                     input logic [15:0] exp_ret);
    check({name, "_irq"}, 32'(irq), 32'(exp_irq));
    check({name, "_cause"}, cause, exp_cause);
    check({name, "_ret"}, 32'(ret), 32'(exp_ret));
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; mie = '0; ack = 1'b0; mret = 1'b0;
    tick(); tick();
    lit("reset", 1'b0, 32'h0, 16'h0);

    // Single source 2
    rst = 1'b0; mie = 16'h0004;
    tick();
    lit("idle", 1'b0, 32'h0, 16'h0);
    req = 16'h0004; tick();
    lit("single_req", 1'b1, 32'h8000_0012, 16'h0);
    ack = 1'b1; tick(); ack = 1'b0;
    lit("single_svc", 1'b0, 32'h8000_0012, 16'h0);
    mret = 1'b1; tick(); mret = 1'b0; req = 16'h0;
    lit("single_ret", 1'b0, 32'h8000_0012, 16'h0004);
    tick();
    lit("single_done", 1'b0, 32'h8000_0012, 16'h0);

    // Priority: bit 2 over bit 5, then bit 5
    mie = 16'hFFFF; req = 16'h0024; tick();
    lit("prio_first", 1'b1, 32'h8000_0012, 16'h0);
    ack = 1'b1; tick(); ack = 1'b0;
    mret = 1'b1; tick(); mret = 1'b0; req = 16'h0020;
    lit("prio_ret2", 1'b0, 32'h8000_0012, 16'h0004);
    tick();
    lit("prio_gap", 1'b0, 32'h8000_0012, 16'h0);
    tick();
    lit("prio_second", 1'b1, 32'h8000_0015, 16'h0);
    ack = 1'b1; tick(); ack = 1'b0;
    mret = 1'b1; tick(); mret = 1'b0; req = 16'h0;
    lit("prio_ret5", 1'b0, 32'h8000_0015, 16'h0020);
    tick();

    // Mask and withdraw on source 3
    mie = 16'hFFF7; req = 16'h0008; tick(); tick();
    lit("masked", 1'b0, 32'h8000_0015, 16'h0);
    mie = 16'hFFFF; tick();
    lit("unmasked", 1'b1, 32'h8000_0013, 16'h0);
    mie = 16'hFFF7; tick();
    lit("withdrawn", 1'b0, 32'h8000_0013, 16'h0);
    tick();
    lit("withdrawn2", 1'b0, 32'h8000_0013, 16'h0);
    req = 16'h0; mie = 16'hFFFF; tick();

    // No preemption: source 0 raised while 7 is in service
    req = 16'h0080; tick();
    lit("np_req7", 1'b1, 32'h8000_0017, 16'h0);
    ack = 1'b1; tick(); ack = 1'b0; req = 16'h0081;
    tick();
    lit("np_svc", 1'b0, 32'h8000_0017, 16'h0);
    mret = 1'b1; tick(); mret = 1'b0; req = 16'h0001;
    lit("np_ret7", 1'b0, 32'h8000_0017, 16'h0080);
    tick(); tick();
    lit("np_req0", 1'b1, 32'h8000_0010, 16'h0);
    ack = 1'b1; tick(); ack = 1'b0;
    mret = 1'b1; tick(); mret = 1'b0; req = 16'h0;
    lit("np_ret0", 1'b0, 32'h8000_0010, 16'h0001);
    tick();

    // Reset mid-service, source held across reset is re-arbitrated
    req = 16'h0002; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    rst = 1'b1; mret = 1'b1; tick(); mret = 1'b0;
    lit("rst_svc", 1'b0, 32'h0, 16'h0);
    rst = 1'b0; mret = 1'b1; tick(); mret = 1'b0;
    lit("rst_rearb", 1'b1, 32'h8000_0011, 16'h0);
    req = 16'h0; tick();
    lit("rst_withdraw", 1'b0, 32'h8000_0011, 16'h0);

    // Ack beats withdraw; stray mret in idle
    req = 16'h0010; tick();
    ack = 1'b1; req = 16'h0; tick(); ack = 1'b0;
    lit("ackwd_svc", 1'b0, 32'h8000_0014, 16'h0);
    mret = 1'b1; tick(); mret = 1'b0;
    lit("ackwd_ret", 1'b0, 32'h8000_0014, 16'h0010);
    tick();
    mret = 1'b1; ack = 1'b1; tick(); mret = 1'b0; ack = 1'b0;
    lit("stray_mret", 1'b0, 32'h8000_0014, 16'h0);

    // Randomized traffic; sources drop their request once returned
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) mie = 16'($urandom) | 16'($urandom);
      req  = (req & ~m_ret) | (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 9) == 0) req = req & 16'($urandom);
      ack  = ($urandom_range(0, 2) == 0);
      mret = ($urandom_range(0, 2) == 0);
      tick();
    end

    rst = 1'b0; req = '0; ack = 1'b0; mret = 1'b0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter N_SRC, default 16, SHALL set the number of interrupt sources (1..16).
REQ-002 Parameter CAUSE_BASE, default 32'h8000_0010, SHALL set the mcause value reported for source 0.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the synchronous, active-high reset.
REQ-005 irq_req_i  input  N_SRC  SHALL carry level-sensitive peripheral requests; bit k is held by source k until it receives its return pulse.
REQ-006 mie_i  input  N_SRC  SHALL carry per-source enable bits from the core CSR.
REQ-007 irq_ack_i  input  1  SHALL be a one-cycle pulse from the core when it enters the trap.
REQ-008 mret_i  input  1  SHALL be a one-cycle pulse from the core when it executes mret.
REQ-009 irq_o  output  1  SHALL be the registered interrupt request to the core.
REQ-010 irq_cause_o  output  32  SHALL be the registered cause of the selected source.
REQ-011 irq_ret_o  output  N_SRC  SHALL be the registered one-hot return pulse to the serviced source.

Function
REQ-012 The block SHALL implement a four-state FSM: IDLE, REQ, SERVICE, RET.
REQ-013 IDLE: pending = irq_req_i & mie_i; if pending != 0, the block SHALL latch sel = index of lowest set bit (fixed priority, bit 0 highest) and go to REQ.
REQ-014 irq_o SHALL be 1 exactly while in REQ; latency is 1 cycle from pending becoming nonzero in IDLE to irq_o = 1.
REQ-015 irq_cause_o SHALL be loaded with CAUSE_BASE + sel on the IDLE->REQ transition and held unchanged through REQ, SERVICE and RET.
REQ-016 REQ with irq_ack_i = 1 SHALL go to SERVICE (irq_o = 0 the next cycle).
REQ-017 REQ with irq_ack_i = 0 and (irq_req_i[sel] & mie_i[sel]) = 0 SHALL withdraw to IDLE (irq_o = 0 the next cycle, no return pulse); ack takes priority if both occur in the same cycle.
REQ-018 sel SHALL NOT change while in REQ even if a higher-priority source becomes pending (no preemption).
REQ-019 SERVICE SHALL ignore irq_req_i and mie_i; mret_i = 1 SHALL go to RET.
REQ-020 RET SHALL last exactly one cycle with irq_ret_o = one-hot(sel), then go to IDLE; irq_ret_o SHALL be 0 in all other states.
REQ-021 mret_i in IDLE or REQ SHALL be ignored; irq_ack_i outside REQ SHALL be ignored.
REQ-022 After RET, IDLE SHALL re-evaluate pending in its first cycle, so back-to-back interrupts have a minimum 2-cycle gap between irq_o deassert (RET) and reassert.
REQ-023 Source indices >= N_SRC SHALL never be selected; sel width SHALL be 4 bits.

Reset
REQ-024 rst_i = 1 at a clock edge SHALL force state IDLE, sel = 0, irq_o = 0, irq_cause_o = 0 and irq_ret_o = 0 on that edge, from any state including mid-service.
REQ-025 Reset SHALL have priority over irq_ack_i and mret_i in the same cycle.
REQ-026 A source held high across reset SHALL be re-arbitrated from IDLE after rst_i deasserts (irq_o = 1 one cycle later if enabled).

Verification
REQ-027 Single source: mie_i = 16'h0004, irq_req_i[2] rises -> irq_o = 1 the next cycle, irq_cause_o = 32'h8000_0012; ack -> irq_o = 0; mret -> irq_ret_o = 16'h0004 for one cycle.
REQ-028 Priority: irq_req_i = 16'h0024 with all enabled -> sel = 2; after its return, with bit 2 dropped -> bit 5 served, cause 32'h8000_0015.
REQ-029 Mask and withdraw: mie_i[3] = 0 with irq_req_i[3] = 1 -> irq_o stays 0; enable, then clear mie_i[3] before ack -> irq_o drops, irq_ret_o stays 0.
REQ-030 No preemption: source 7 in SERVICE, raise source 0 -> irq_o stays 0 until RET; source 0 is served after.
REQ-031 Reset mid-SERVICE: rst_i pulsed -> all outputs 0; subsequent mret_i produces no irq_ret_o pulse.
REQ-032 Simultaneous ack and withdraw in REQ -> transition to SERVICE; a stray mret_i in IDLE -> no output change.
